// File: rtl/av_bus_arbiter.sv
// Two-requester Avalon-MM arbiter: instruction fetch (port 0, read-only) and
// data memory (port 1, read/write) share one bus master; grant held per burst.
//
// state    | meaning
// IDLE     | no owner, sample requests, pick winner (round-robin on contention)
// CMD      | owner's command presented on av_*, waiting for acceptance
// WR_BURST | remaining write beats of an accepted write burst
// RD_WAIT  | read accepted, counting returned readdatavalid beats
module av_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 5
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [ADDR_W-1:0]  i_address,
    input  logic               i_read,
    input  logic [BURST_W-1:0] i_burstcount,
    output logic               i_waitrequest,
    output logic [DATA_W-1:0]  i_readdata,
    output logic               i_readdatavalid,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [DATA_W-1:0]  d_writedata,
    input  logic [BURST_W-1:0] d_burstcount,
    output logic               d_waitrequest,
    output logic [DATA_W-1:0]  d_readdata,
    output logic               d_readdatavalid,
    output logic [ADDR_W-1:0]  av_address,
    output logic               av_read,
    output logic               av_write,
    output logic [DATA_W-1:0]  av_writedata,
    output logic [BURST_W-1:0] av_burstcount,
    input  logic               av_waitrequest,
    input  logic [DATA_W-1:0]  av_readdata,
    input  logic               av_readdatavalid,
    output logic [1:0]         grant
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WR_BURST,
        S_RD_WAIT
    } state_t;

    localparam logic [BURST_W-1:0] BC_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic               last_d;
    logic [BURST_W-1:0] beat_cnt;

    logic               own_i;
    logic               own_d;
    logic               i_req;
    logic               d_req;
    logic               pick_d;
    logic [BURST_W-1:0] i_len;
    logic [BURST_W-1:0] d_len;

    assign own_i = grant[0];
    assign own_d = grant[1];
    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // A zero burstcount is a single beat everywhere, including on the bus.
    assign i_len = (i_burstcount == '0) ? BC_ONE : i_burstcount;
    assign d_len = (d_burstcount == '0) ? BC_ONE : d_burstcount;

    // Round-robin: under contention the port that did not win last time wins.
    assign pick_d = (i_req && d_req) ? !last_d : d_req;

    assign i_readdata   = av_readdata;
    assign d_readdata   = av_readdata;
    assign av_writedata = d_writedata;

    always_comb begin
        av_address      = own_d ? d_address : i_address;
        av_burstcount   = own_d ? d_len : i_len;
        av_read         = 1'b0;
        av_write        = 1'b0;
        i_waitrequest   = 1'b1;
        d_waitrequest   = 1'b1;
        i_readdatavalid = 1'b0;
        d_readdatavalid = 1'b0;
        case (state)
            S_CMD: begin
                if (own_d) begin
                    av_write      = d_write;
                    av_read       = d_read & ~d_write;
                    d_waitrequest = av_waitrequest;
                end else if (own_i) begin
                    av_read       = i_read;
                    i_waitrequest = av_waitrequest;
                end
            end
            S_WR_BURST: begin
                av_write      = d_write;
                d_waitrequest = av_waitrequest;
            end
            S_RD_WAIT: begin
                i_readdatavalid = own_i & av_readdatavalid;
                d_readdatavalid = own_d & av_readdatavalid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= S_IDLE;
            grant    <= 2'b00;
            last_d   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        grant  <= pick_d ? 2'b10 : 2'b01;
                        last_d <= pick_d;
                        state  <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (own_d) begin
                        if (!d_req) begin
                            state <= S_IDLE;
                            grant <= 2'b00;
                        end else if (!av_waitrequest) begin
                            if (d_write) begin
                                beat_cnt <= d_len - BC_ONE;
                                if (d_len == BC_ONE) begin
                                    state <= S_IDLE;
                                    grant <= 2'b00;
                                end else begin
                                    state <= S_WR_BURST;
                                end
                            end else begin
                                beat_cnt <= d_len;
                                state    <= S_RD_WAIT;
                            end
                        end
                    end else begin
                        if (!i_req) begin
                            state <= S_IDLE;
                            grant <= 2'b00;
                        end else if (!av_waitrequest) begin
                            beat_cnt <= i_len;
                            state    <= S_RD_WAIT;
                        end
                    end
                end
                S_WR_BURST: begin
                    if (d_write && !av_waitrequest) begin
                        beat_cnt <= beat_cnt - BC_ONE;
                        if (beat_cnt == BC_ONE) begin
                            state <= S_IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (av_readdatavalid) begin
                        beat_cnt <= beat_cnt - BC_ONE;
                        if (beat_cnt == BC_ONE) begin
                            state <= S_IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_av_bus_arbiter.sv
// Bench for av_bus_arbiter: bus responder model plus scoreboard queues for
// read beats per port, write beats and the round-robin grant order.
module tb_av_bus_arbiter;

    logic        clk;
    logic        clrn;
    logic [31:0] i_address;
    logic        i_read;
    logic [4:0]  i_burstcount;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic        i_readdatavalid;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [4:0]  d_burstcount;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic        d_readdatavalid;
    logic [31:0] av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [4:0]  av_burstcount;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;
    logic [1:0]  grant;

    av_bus_arbiter dut (
        .clk(clk), .clrn(clrn),
        .i_address(i_address), .i_read(i_read), .i_burstcount(i_burstcount),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .i_readdatavalid(i_readdatavalid),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_burstcount(d_burstcount),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .d_readdatavalid(d_readdatavalid),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_burstcount(av_burstcount),
        .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .av_readdatavalid(av_readdatavalid),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          i_beats = 0;
    int          d_beats = 0;
    int          wr_cnt  = 0;
    logic [31:0] i_exp[$];
    logic [31:0] d_exp[$];
    logic [31:0] wr_exp[$];
    logic [31:0] rd_beats[$];
    logic [1:0]  grant_exp[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a, input int k);
        return (a ^ 32'hC3A5_0000) + k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            sample();
            if (grant == 2'b00) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("idle_timeout", 1, 0);
    endtask

    // Issues n back-to-back read bursts on one port, holding each request
    // until the arbiter accepts it.
    task automatic rd_master(input bit port, input int n, input logic [31:0] base,
                             input logic [4:0] len);
        int el;
        bit acc;
        el = (len == 5'd0) ? 1 : int'(len);
        for (int k = 0; k < n; k++) begin
            tick();
            if (port) begin
                d_read = 1'b1; d_address = base + 32'(k * 64); d_burstcount = len;
                for (int b = 0; b < el; b++) d_exp.push_back(rd_data(d_address, b));
            end else begin
                i_read = 1'b1; i_address = base + 32'(k * 64); i_burstcount = len;
                for (int b = 0; b < el; b++) i_exp.push_back(rd_data(i_address, b));
            end
            acc = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                #1;
                if (port ? (d_read && !d_waitrequest) : (i_read && !i_waitrequest)) begin
                    acc = 1'b1;
                    break;
                end
            end
            if (!acc) check("rd_accept_timeout", 0, 1);
        end
        tick();
        if (port) d_read = 1'b0;
        else i_read = 1'b0;
    endtask

    // Bus responder: returns one read beat per cycle for every accepted burst.
    initial begin
        av_readdatavalid = 1'b0;
        av_readdata      = '0;
        forever begin
            tick();
            if (rd_beats.size() > 0) begin
                av_readdatavalid = 1'b1;
                av_readdata      = rd_beats.pop_front();
            end else begin
                av_readdatavalid = 1'b0;
                av_readdata      = $urandom;
            end
        end
    end

    // Monitor: bus acceptance, write-data scoreboard, per-port read scoreboard, grant order.
    initial begin
        int nb;
        logic [1:0] prev_grant;
        prev_grant = 2'b00;
        forever begin
            @(negedge clk);
            if (av_read && !av_waitrequest) begin
                nb = (av_burstcount == 5'd0) ? 1 : int'(av_burstcount);
                for (int k = 0; k < nb; k++) rd_beats.push_back(rd_data(av_address, k));
            end
            if (av_write && !av_waitrequest) begin
                wr_cnt++;
                if (wr_exp.size() == 0) check("wr_stray", 1, 0);
                else check("wr_data", av_writedata, wr_exp.pop_front());
            end
            if (i_readdatavalid) begin
                i_beats++;
                if (i_exp.size() == 0) check("i_rdv_stray", 1, 0);
                else check("i_rdata", i_readdata, i_exp.pop_front());
            end
            if (d_readdatavalid) begin
                d_beats++;
                if (d_exp.size() == 0) check("d_rdv_stray", 1, 0);
                else check("d_rdata", d_readdata, d_exp.pop_front());
            end
            if (grant != prev_grant && grant != 2'b00 && grant_exp.size() > 0)
                check("rr_grant", grant, grant_exp.pop_front());
            prev_grant = grant;
        end
    end

    initial begin
        int b0;
        int w0;
        bit seen;
        clrn = 1'b0;
        i_address = '0; i_read = 1'b0; i_burstcount = '0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0; d_burstcount = '0;
        av_waitrequest = 1'b0;

        // reset state
        sample();
        sample();
        check("rst_grant", grant, 2'b00);
        check("rst_av_read", av_read, 0);
        check("rst_av_write", av_write, 0);
        check("rst_i_wait", i_waitrequest, 1);
        check("rst_d_wait", d_waitrequest, 1);
        check("rst_i_rdv", i_readdatavalid, 0);
        check("rst_d_rdv", d_readdatavalid, 0);
        clrn = 1'b1;
        sample();

        // port0 read burst 4, no wait states
        b0 = i_beats;
        tick();
        i_read = 1'b1; i_address = 32'h0000_1100; i_burstcount = 5'd4;
        for (int k = 0; k < 4; k++) i_exp.push_back(rd_data(32'h0000_1100, k));
        sample();
        check("t1_av_read_lat0", av_read, 0);
        check("t1_grant_lat0", grant, 2'b00);
        tick();
        sample();
        check("t1_av_read", av_read, 1);
        check("t1_grant", grant, 2'b01);
        check("t1_av_addr", av_address, 32'h0000_1100);
        check("t1_av_bc", av_burstcount, 5'd4);
        check("t1_i_wait", i_waitrequest, 0);
        check("t1_d_wait", d_waitrequest, 1);
        tick();
        i_read = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sample();
            check("t1_grant_hold", grant, 2'b01);
            check("t1_d_rdv", d_readdatavalid, 0);
            if (i_beats - b0 == 4) begin
                seen = 1'b1;
                break;
            end
        end
        check("t1_beats", seen, 1);
        sample();
        check("t1_release", grant, 2'b00);

        // port1 write burst 3, bus stalls 2 cycles on beat 2
        w0 = wr_cnt;
        tick();
        d_write = 1'b1; d_address = 32'h0000_2200; d_burstcount = 5'd3; d_writedata = 32'hAAAA_0000;
        wr_exp.push_back(32'hAAAA_0000);
        sample();
        check("t3_d_wait_idle", d_waitrequest, 1);
        tick();
        sample();
        check("t3_grant", grant, 2'b10);
        check("t3_av_write", av_write, 1);
        check("t3_av_bc", av_burstcount, 5'd3);
        check("t3_d_wait0", d_waitrequest, 0);
        tick();
        d_writedata = 32'hAAAA_0001; wr_exp.push_back(32'hAAAA_0001);
        av_waitrequest = 1'b1;
        sample();
        check("t3_stall1", d_waitrequest, 1);
        tick();
        sample();
        check("t3_stall2", d_waitrequest, 1);
        check("t3_stall_write", av_write, 1);
        tick();
        av_waitrequest = 1'b0;
        sample();
        check("t3_unstall", d_waitrequest, 0);
        tick();
        d_writedata = 32'hAAAA_0002; wr_exp.push_back(32'hAAAA_0002);
        sample();
        tick();
        d_write = 1'b0;
        sample();
        check("t3_idle", grant, 2'b00);
        check("t3_wr_beats", wr_cnt - w0, 3);
        sample();
        check("t3_no_more_wr", wr_cnt - w0, 3);

        // port1 read burst 2 while port0 waits
        b0 = d_beats;
        tick();
        d_read = 1'b1; d_address = 32'h0000_3300; d_burstcount = 5'd2;
        for (int k = 0; k < 2; k++) d_exp.push_back(rd_data(32'h0000_3300, k));
        sample();
        tick();
        i_read = 1'b1; i_address = 32'h0000_4400; i_burstcount = 5'd1;
        i_exp.push_back(rd_data(32'h0000_4400, 0));
        sample();
        check("t4_grant", grant, 2'b10);
        check("t4_i_wait_cmd", i_waitrequest, 1);
        tick();
        d_read = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sample();
            check("t4_i_stall", i_waitrequest, 1);
            check("t4_i_rdv", i_readdatavalid, 0);
            if (d_beats - b0 == 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_beats", seen, 1);
        sample();
        check("t4_gap", grant, 2'b00);
        sample();
        check("t4_i_grant", grant, 2'b01);
        check("t4_i_wait_own", i_waitrequest, 0);
        tick();
        i_read = 1'b0;
        wait_idle();

        // reset mid read burst after 1 of 4 beats
        repeat (3) sample();
        b0 = i_beats;
        tick();
        i_read = 1'b1; i_address = 32'h0000_5500; i_burstcount = 5'd4;
        for (int k = 0; k < 4; k++) i_exp.push_back(rd_data(32'h0000_5500, k));
        tick();
        sample();
        tick();
        i_read = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sample();
            if (i_beats - b0 == 1) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_first_beat", seen, 1);
        clrn = 1'b0;
        #1;
        check("t5_grant_async", grant, 2'b00);
        check("t5_rdv_async", i_readdatavalid, 0);
        check("t5_i_wait", i_waitrequest, 1);
        i_exp.delete();
        sample();
        check("t5_rdv_in_rst", i_readdatavalid, 0);
        clrn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            check("t5_i_drop", i_readdatavalid, 0);
            check("t5_d_drop", d_readdatavalid, 0);
        end
        check("t5_beats_after", i_beats - b0, 1);

        // burstcount 0 read is one beat
        b0 = i_beats;
        tick();
        i_read = 1'b1; i_address = 32'h0000_6600; i_burstcount = 5'd0;
        i_exp.push_back(rd_data(32'h0000_6600, 0));
        sample();
        tick();
        sample();
        check("t6_av_read", av_read, 1);
        tick();
        i_read = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sample();
            if (i_beats - b0 == 1) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_beat", seen, 1);
        sample();
        check("t6_release", grant, 2'b00);
        repeat (3) sample();
        check("t6_one_beat", i_beats - b0, 1);

        // contention after reset: port1 first, then strict alternation
        clrn = 1'b0;
        sample();
        clrn = 1'b1;
        sample();
        for (int k = 0; k < 3; k++) begin
            grant_exp.push_back(2'b10);
            grant_exp.push_back(2'b01);
        end
        fork
            rd_master(1'b0, 3, 32'h0001_0000, 5'd2);
            rd_master(1'b1, 3, 32'h0002_0000, 5'd1);
        join
        wait_idle();
        repeat (4) sample();
        check("rr_grants_left", grant_exp.size(), 0);
        check("rr_i_left", i_exp.size(), 0);
        check("rr_d_left", d_exp.size(), 0);
        check("wr_left", wr_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
